// File: rtl/mem_check_scoreboard_pkg.sv
// Shared types and constants for the memory check scoreboard.
package mem_check_scoreboard_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [31:0] STOP_WORD_DEFAULT = 32'hff00_0000;

endpackage

// File: rtl/mem_check_scoreboard_if.sv
// Memory check port: read strobe/address out, data plus expected word and mask back.
interface mem_check_scoreboard_if #(
    parameter int DATA_W = 256,
    parameter int ADDR_W = 16
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] exp_data;
    logic [DATA_W-1:0] exp_mask;

    modport master (
        output rd_en,
        output rd_addr,
        input  rd_data,
        input  exp_data,
        input  exp_mask
    );

    modport slave (
        input  rd_en,
        input  rd_addr,
        output rd_data,
        output exp_data,
        output exp_mask
    );
endinterface

// File: rtl/mem_check_scoreboard_mask_compare.sv
// Masked inequality of one memory word; a zero mask bit is a don't-care.
module mask_compare #(
    parameter int DATA_W = 256
) (
    input  logic [DATA_W-1:0] data,
    input  logic [DATA_W-1:0] expected,
    input  logic [DATA_W-1:0] mask,
    output logic              mismatch
);
    assign mismatch = |((data ^ expected) & mask);
endmodule

// File: rtl/mem_check_scoreboard.sv
// Snoops the system bus for a stop word, then reads every memory location once
// and records which ones differ from the expected contents under a mask.
module mem_check_scoreboard
    import mem_check_scoreboard_pkg::*;
#(
    parameter int          DATA_W    = 256,
    parameter int          DEPTH     = 14,
    parameter int          ADDR_W    = 16,
    parameter logic [31:0] STOP_WORD = STOP_WORD_DEFAULT,
    localparam int         CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                   Clk,
    input  logic                   nReset,
    input  logic [DATA_W-1:0]      DataBus,
    input  logic                   clear,
    mem_check_scoreboard_if.master mem,
    output logic                   busy,
    output logic                   done,
    output logic                   fail,
    output logic [DEPTH-1:0]       fail_vec,
    output logic [CNT_W-1:0]       err_count,
    output logic [ADDR_W-1:0]      first_fail
);

    state_t              state_reg, state_next;
    logic                rd_en_reg, rd_en_next;
    logic [ADDR_W-1:0]   rd_addr_reg, rd_addr_next;
    logic                cmp_valid_reg, cmp_valid_next;
    logic [ADDR_W-1:0]   cmp_idx_reg, cmp_idx_next;
    logic [DEPTH-1:0]    fail_vec_reg, fail_vec_next;
    logic [CNT_W-1:0]    err_count_reg, err_count_next;
    logic [ADDR_W-1:0]   first_fail_reg, first_fail_next;

    logic                mismatch;
    logic                trigger;
    logic                last_issue;
    logic                last_cmp;
    logic [DEPTH-1:0]    hit_vec;

    // Only the low 32 bits of the snooped bus carry the trigger pattern.
    if (DATA_W > 32) begin : g_unused_bus
        logic unused_bus_bits;
        assign unused_bus_bits = ^DataBus[DATA_W-1:32];
    end

    mask_compare #(.DATA_W(DATA_W)) u_mask_compare (
        .data     (mem.rd_data),
        .expected (mem.exp_data),
        .mask     (mem.exp_mask),
        .mismatch (mismatch)
    );

    assign trigger    = (DataBus[31:0] == STOP_WORD) && !clear;
    assign last_issue = (rd_addr_reg == ADDR_W'(DEPTH - 1));
    assign last_cmp   = cmp_valid_reg && (cmp_idx_reg == ADDR_W'(DEPTH - 1));

    // One-hot record of the location being compared this cycle, if it failed.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
        assign hit_vec[gi] = cmp_valid_reg && mismatch && (cmp_idx_reg == ADDR_W'(gi));
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_reg      <= ST_IDLE;
            rd_en_reg      <= 1'b0;
            rd_addr_reg    <= '0;
            cmp_valid_reg  <= 1'b0;
            cmp_idx_reg    <= '0;
            fail_vec_reg   <= '0;
            err_count_reg  <= '0;
            first_fail_reg <= '0;
        end else begin
            state_reg      <= state_next;
            rd_en_reg      <= rd_en_next;
            rd_addr_reg    <= rd_addr_next;
            cmp_valid_reg  <= cmp_valid_next;
            cmp_idx_reg    <= cmp_idx_next;
            fail_vec_reg   <= fail_vec_next;
            err_count_reg  <= err_count_next;
            first_fail_reg <= first_fail_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        rd_en_next      = 1'b0;
        rd_addr_next    = '0;
        cmp_valid_next  = 1'b0;
        cmp_idx_next    = '0;
        fail_vec_next   = fail_vec_reg;
        err_count_next  = err_count_reg;
        first_fail_next = first_fail_reg;

        if (clear) begin
            state_next      = ST_IDLE;
            fail_vec_next   = '0;
            err_count_next  = '0;
            first_fail_next = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (trigger) begin
                        state_next = ST_SCAN;
                        rd_en_next = 1'b1;
                    end
                end
                ST_SCAN: begin
                    // Issue stops after the last address; the scan ends one
                    // cycle later when that location's data has been compared.
                    if (rd_en_reg && !last_issue) begin
                        rd_en_next   = 1'b1;
                        rd_addr_next = rd_addr_reg + ADDR_W'(1);
                    end
                    cmp_valid_next = rd_en_reg;
                    cmp_idx_next   = rd_addr_reg;
                    if (|hit_vec) begin
                        fail_vec_next = fail_vec_reg | hit_vec;
                        if (err_count_reg < CNT_W'(DEPTH)) begin
                            err_count_next = err_count_reg + CNT_W'(1);
                        end
                        if (fail_vec_reg == '0) begin
                            first_fail_next = cmp_idx_reg;
                        end
                    end
                    if (last_cmp) begin
                        state_next = ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_next = ST_DONE;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    assign mem.rd_en   = rd_en_reg;
    assign mem.rd_addr = rd_addr_reg;
    assign busy        = (state_reg == ST_SCAN);
    assign done        = (state_reg == ST_DONE);
    assign fail        = |fail_vec_reg;
    assign fail_vec    = fail_vec_reg;
    assign err_count   = err_count_reg;
    assign first_fail  = first_fail_reg;

endmodule
